// File: rtl/fixed_point_iter_mult_pkg.sv
// Shared types and sizing helpers for the iterative fixed-point multiplier.
package fixed_point_iter_mult_pkg;

   // Controller state encoding; 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Iteration counter width: wide enough to hold n-1 with one bit of headroom.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fixed_point_iter_mult_ctrl.sv
// Sequencer for the iterative multiplier: FSM, iteration counter, handshake decode.
module fixed_point_iter_mult_ctrl
   import fixed_point_iter_mult_pkg::*;
#(
   parameter int unsigned n = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic recv_val_i,
   input  logic send_rdy_i,
   output logic recv_rdy_o,
   output logic send_val_o,
   output logic calc_o,
   output logic last_o
);

   localparam int unsigned CW = cnt_width(n);

   state_e          state;
   state_e          next_state;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt_q <= '0;
      end else begin
         state <= next_state;
         cnt_q <= cnt_d;
      end
   end

   // Next-state and counter update.
   always_comb begin
      next_state = state;
      cnt_d      = cnt_q;
      case (state)
         IDLE: begin
            if (recv_val_i) begin
               next_state = CALC;
               cnt_d      = '0;
            end
         end
         CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(n - 1)) next_state = DONE;
         end
         DONE: begin
            if (send_rdy_i) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign recv_rdy_o = (state == IDLE);
   assign send_val_o = (state == DONE);
   assign calc_o     = (state == CALC);
   assign last_o     = (state == CALC) && (cnt_q == CW'(n - 1));

endmodule

// File: rtl/fixed_point_iter_mult.sv
// Iterative shift-add fixed-point multiplier, one multiplier bit per cycle.
module fixed_point_iter_mult
   import fixed_point_iter_mult_pkg::*;
#(
   parameter int unsigned n    = 32,
   parameter int unsigned d    = 16,
   parameter bit          sign = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   output logic         recv_rdy,
   input  logic         recv_val,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         send_rdy,
   output logic         send_val,
   output logic [n-1:0] c
);

   logic accept;
   logic calc;
   logic last;

   logic [2*n-1:0] a_q, a_d;
   logic [2*n-1:0] acc_q, acc_d;
   logic [n-1:0]   b_q, b_d;
   logic [n-1:0]   c_q, c_d;

   fixed_point_iter_mult_ctrl #(.n(n)) control (
      .clk        (clk),
      .reset      (reset),
      .recv_val_i (recv_val),
      .send_rdy_i (send_rdy),
      .recv_rdy_o (recv_rdy),
      .send_val_o (send_val),
      .calc_o     (calc),
      .last_o     (last)
   );

   assign accept = recv_val && recv_rdy;

   // Operand load on accept, then one shift-add (or final subtract) step per CALC cycle.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      c_d   = c_q;
      if (accept) begin
         a_d   = sign ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
         b_d   = b;
         acc_d = '0;
      end else if (calc) begin
         if (b_q[0]) begin
            // The multiplier MSB carries negative weight in two's complement.
            acc_d = (sign && last) ? (acc_q - a_q) : (acc_q + a_q);
         end
         a_d = a_q << 1;
         b_d = b_q >> 1;
         if (last) c_d = acc_d[n+d-1:d];
      end
   end

   // Datapath registers; c holds the last result until the next completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         c_q   <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         c_q   <= c_d;
      end
   end

   assign c = c_q;

endmodule

// File: tb/tb_fixed_point_iter_mult.sv
// Self-checking bench: unsigned and signed multiplier instances against an arithmetic model.
module tb_fixed_point_iter_mult;

   localparam int unsigned N = 32;
   localparam int unsigned D = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          rr  [2];
   logic          rv  [2];
   logic [N-1:0]  av  [2];
   logic [N-1:0]  bv  [2];
   logic          srdy[2];
   logic          sv  [2];
   logic [N-1:0]  cv  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fixed_point_iter_mult #(.n(N), .d(D), .sign(1'b0)) dut_u (
      .clk(clk), .reset(reset), .recv_rdy(rr[0]), .recv_val(rv[0]),
      .a(av[0]), .b(bv[0]), .send_rdy(srdy[0]), .send_val(sv[0]), .c(cv[0])
   );

   fixed_point_iter_mult #(.n(N), .d(D), .sign(1'b1)) dut_s (
      .clk(clk), .reset(reset), .recv_rdy(rr[1]), .recv_val(rv[1]),
      .a(av[1]), .b(bv[1]), .send_rdy(srdy[1]), .send_val(sv[1]), .c(cv[1])
   );

   // Reference: full product, drop D fractional bits, keep N bits.
   function automatic logic [N-1:0] model(input bit s, input logic [N-1:0] x, input logic [N-1:0] y);
      logic [63:0] p;
      if (s) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else   p = {32'b0, x} * {32'b0, y};
      return p[D+N-1:D];
   endfunction

   // One full transaction on instance s; busy=1 keeps recv_val high during CALC with other operands.
   task automatic txn(input int s, input logic [N-1:0] x, input logic [N-1:0] y,
                      input int hold, input bit busy);
      logic [N-1:0] exp_c;
      logic [N-1:0] held;
      int lat;
      exp_c = model(s[0], x, y);
      @(negedge clk);
      av[s] = x; bv[s] = y; rv[s] = 1'b1; srdy[s] = 1'b0;
      checks++;
      if (rr[s] !== 1'b1) begin
         errors++; $display("FAIL accept_rdy inst=%0d got=%b want=1", s, rr[s]);
      end
      @(posedge clk); #1;
      if (busy) begin av[s] = ~x; bv[s] = ~y; end
      else rv[s] = 1'b0;
      lat = 1;
      while (sv[s] !== 1'b1 && lat < 100) begin
         checks++;
         if (rr[s] !== 1'b0) begin
            errors++; $display("FAIL busy_rdy inst=%0d cyc=%0d got=%b want=0", s, lat, rr[s]);
         end
         if (s == 0) begin
            checks++;
            if (dut_u.control.state !== 2'd1) begin
               errors++; $display("FAIL calc_state cyc=%0d got=%0d want=1", lat, dut_u.control.state);
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      rv[s] = 1'b0;
      checks++;
      if (lat != N + 1) begin
         errors++; $display("FAIL latency inst=%0d got=%0d want=%0d", s, lat, N + 1);
         return;
      end
      checks++;
      if (cv[s] !== exp_c) begin
         errors++; $display("FAIL result inst=%0d a=%h b=%h got=%h want=%h", s, x, y, cv[s], exp_c);
      end
      held = cv[s];
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checks++;
         if (sv[s] !== 1'b1 || cv[s] !== held) begin
            errors++; $display("FAIL hold inst=%0d cyc=%0d val=%b c=%h want_val=1 c=%h", s, i, sv[s], cv[s], held);
         end
      end
      @(negedge clk); srdy[s] = 1'b1;
      @(posedge clk); #1; srdy[s] = 1'b0;
      checks++;
      if (rr[s] !== 1'b1 || sv[s] !== 1'b0 || cv[s] !== exp_c) begin
         errors++; $display("FAIL release inst=%0d rdy=%b val=%b c=%h want rdy=1 val=0 c=%h", s, rr[s], sv[s], cv[s], exp_c);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (rr[s] !== 1'b1 || sv[s] !== 1'b0 || cv[s] !== '0) begin
            errors++; $display("FAIL reset inst=%0d rdy=%b val=%b c=%h want 1 0 0", s, rr[s], sv[s], cv[s]);
         end
      end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_directed();
      txn(0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
      txn(0, 32'h0002_8000, 32'h0001_8000, 0, 1'b0);
      txn(0, 32'h0000_0000, $urandom, 0, 1'b0);
      txn(0, $urandom, 32'h0000_0000, 0, 1'b0);
      txn(0, 32'h0000_0001, 32'h0000_0001, 0, 1'b0);
      txn(0, 32'h0100_0000, 32'h0100_0000, 0, 1'b0);
      txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
   endtask

   task automatic test_signed();
      txn(1, 32'hFFFF_0000, 32'h0002_8000, 0, 1'b0);
      txn(1, 32'hFFFF_8000, 32'hFFFF_8000, 0, 1'b0);
      txn(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      txn(1, 32'h0003_0000, 32'hFFFE_0000, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      txn(0, 32'h0003_4000, 32'h0000_C000, 10, 1'b1);
      txn(1, 32'hFFF0_1234, 32'h0004_5678, 10, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         txn(i % 2, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      av[0] = 32'h0005_0000; bv[0] = 32'h0002_0000; rv[0] = 1'b1; srdy[0] = 1'b0;
      @(posedge clk); #1; rv[0] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_u.control.state !== 2'd0 || rr[0] !== 1'b1 || sv[0] !== 1'b0 || cv[0] !== '0) begin
         errors++; $display("FAIL mid_reset state=%0d rdy=%b val=%b c=%h want 0 1 0 0",
                            dut_u.control.state, rr[0], sv[0], cv[0]);
      end
      @(negedge clk); reset = 1'b0;
      txn(0, 32'h0005_0000, 32'h0002_0000, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      int cyc = 0;
      int acc_t[$];
      @(negedge clk);
      av[0] = 32'h0001_8000; bv[0] = 32'h0002_0000; rv[0] = 1'b1; srdy[0] = 1'b1;
      for (int i = 0; i < 3 * (N + 2); i++) begin
         if (rr[0] === 1'b1) acc_t.push_back(cyc);
         if (sv[0] === 1'b1) begin
            checks++;
            if (cv[0] !== model(1'b0, 32'h0001_8000, 32'h0002_0000)) begin
               errors++; $display("FAIL b2b_result got=%h want=%h", cv[0], model(1'b0, 32'h0001_8000, 32'h0002_0000));
            end
         end
         @(negedge clk);
         cyc++;
      end
      rv[0] = 1'b0;
      checks++;
      if (acc_t.size() < 3) begin
         errors++; $display("FAIL b2b_count got=%0d want>=3", acc_t.size());
      end else begin
         for (int k = 1; k < acc_t.size(); k++) begin
            checks++;
            if (acc_t[k] - acc_t[k-1] != int'(N + 2)) begin
               errors++; $display("FAIL b2b_interval got=%0d want=%0d", acc_t[k] - acc_t[k-1], N + 2);
            end
         end
      end
      repeat (N + 4) @(negedge clk);
      srdy[0] = 1'b0;
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rv[s] = 1'b0; srdy[s] = 1'b0; av[s] = '0; bv[s] = '0;
      end
      reset = 1'b1;
      test_reset();
      test_directed();
      test_signed();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
